// File: rtl/popcount_rank_decoder.sv
// popcount_rank_decoder: bit-serial colex decoder from (popcount, rank) to a WIDTH-bit word
module popcount_rank_decoder #(
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 4,
   parameter int RANK_W = 7
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CNT_W-1:0]  in_count,
   input  logic [RANK_W-1:0] in_rank,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  O,
   output logic              out_err
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int NK = 2 ** CNT_W;
   localparam logic [CNT_W-1:0] K_MAX = CNT_W'(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
   localparam longint SAT = (longint'(1) << RANK_W) - 1;

   typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

   function automatic logic [RANK_W-1:0] binom(input int n, input int m);
      int s;
      longint c;
      if (m > n) return '0;
      s = (m < n - m) ? m : n - m;
      c = 1;
      for (int j = 0; j < s; j++)
         c = (c * (n - j) / (j + 1) > SAT) ? SAT : c * (n - j) / (j + 1);
      return RANK_W'(c);
   endfunction

   logic [RANK_W-1:0] bin_tab [WIDTH+1][NK];

   for (genvar n = 0; n <= WIDTH; n++) begin : g_row
      for (genvar m = 0; m < NK; m++) begin : g_col
         localparam logic [RANK_W-1:0] V = binom(n, m);
         assign bin_tab[n][m] = V;
      end
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic [RANK_W-1:0] r_q, r_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0]  o_q, o_d;
   logic              err_q, err_d;
   logic [RANK_W-1:0] c_ik;
   logic              hit;
   logic              bad;

   assign c_ik = bin_tab[idx_q][k_q];
   assign hit = (k_q != '0) && (r_q >= c_ik);
   assign bad = (in_count > K_MAX) || (in_rank >= bin_tab[WIDTH][in_count]);
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign O = o_q;
   assign out_err = err_q;

   // next state: validate on accept, resolve one bit per DECODE cycle, hold in DONE until taken
   always_comb begin
      state_d = state_q;
      k_d = k_q;
      r_d = r_q;
      idx_d = idx_q;
      o_d = o_q;
      err_d = err_q;
      case (state_q)
         IDLE: if (in_valid) begin
            o_d = '0;
            err_d = bad;
            state_d = bad ? DONE : DECODE;
            k_d = bad ? k_q : in_count;
            r_d = bad ? r_q : in_rank;
            idx_d = bad ? idx_q : IDX_TOP;
         end
         DECODE: begin
            o_d[idx_q] = hit;
            r_d = hit ? r_q - c_ik : r_q;
            k_d = hit ? k_q - 1'b1 : k_q;
            idx_d = (idx_q == '0) ? idx_q : idx_q - 1'b1;
            state_d = (idx_q == '0) ? DONE : DECODE;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // state register with synchronous active-low reset that abandons any request in flight
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= IDLE;
         k_q <= '0;
         r_q <= '0;
         idx_q <= '0;
         o_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q <= k_d;
         r_q <= r_d;
         idx_q <= idx_d;
         o_q <= o_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_popcount_rank_decoder.sv
// tb_popcount_rank_decoder: directed self-checking bench for the colex rank decoder
module tb_popcount_rank_decoder;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_count = '0;
   logic [6:0] in_rank = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] o;
   logic       out_err;
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         pas [0:8][0:8];

   popcount_rank_decoder #(.WIDTH(8), .CNT_W(4), .RANK_W(7)) dut (
      .CLK(clk), .RESETN(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_count(in_count), .in_rank(in_rank), .out_valid(out_valid),
      .out_ready(out_ready), .O(o), .out_err(out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int colex_rank(input logic [7:0] w);
      int j = 0;
      int s = 0;
      for (int p = 0; p < 8; p++) if (w[p]) begin
         j++;
         s += (j <= p) ? pas[p][j] : 0;
      end
      return s;
   endfunction

   task automatic send(input logic [3:0] k, input logic [6:0] r);
      int n = 0;
      while (!in_ready && n < 30) begin tick(); n++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b required 1", in_ready); end
      in_count = k;
      in_rank = r;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin tick(); lat++; end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      checks += 4;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (o !== 8'h00) begin errors++; $display("FAIL reset_O: got %h want 00", o); end
      if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b0;
      send(4'd2, 7'd1);
      wait_valid(lat);
      checks += 3;
      if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
      if (o !== 8'h05) begin errors++; $display("FAIL basic_O: got %h want 05", o); end
      if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", out_err); end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks += 3;
         if (o !== 8'h05) begin errors++; $display("FAIL basic_hold_O: cycle %0d got %h want 05", c, o); end
         if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready: cycle %0d got %b want 0", c, in_ready); end
         if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_hold_valid: cycle %0d got %b want 1", c, out_valid); end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks += 3;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_release_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release_valid: got %b want 0", out_valid); end
      if (o !== 8'h05) begin errors++; $display("FAIL basic_release_O: got %h want 05", o); end
   endtask

   task automatic test_corners();
      logic [3:0] ck [5] = '{4'd0, 4'd8, 4'd3, 4'd3, 4'd4};
      logic [6:0] cr [5] = '{7'd0, 7'd0, 7'd0, 7'd55, 7'd69};
      logic [7:0] co [5] = '{8'h00, 8'hFF, 8'h07, 8'hE0, 8'hF0};
      int lat;
      for (int t = 0; t < 5; t++) begin
         out_ready = 1'b0;
         send(ck[t], cr[t]);
         wait_valid(lat);
         checks += 3;
         if (lat != 8) begin errors++; $display("FAIL corner_latency k=%0d r=%0d: got %0d want 8", ck[t], cr[t], lat); end
         if (o !== co[t]) begin errors++; $display("FAIL corner_O k=%0d r=%0d: got %h want %h", ck[t], cr[t], o, co[t]); end
         if (out_err !== 1'b0) begin errors++; $display("FAIL corner_err k=%0d r=%0d: got %b want 0", ck[t], cr[t], out_err); end
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_illegal();
      logic [3:0] ik [3] = '{4'd9, 4'd3, 4'd0};
      logic [6:0] ir [3] = '{7'd0, 7'd56, 7'd1};
      int lat;
      for (int t = 0; t < 3; t++) begin
         out_ready = 1'b0;
         send(ik[t], ir[t]);
         wait_valid(lat);
         checks += 3;
         if (lat != 0) begin errors++; $display("FAIL illegal_latency k=%0d r=%0d: got %0d want 0", ik[t], ir[t], lat); end
         if (o !== 8'h00) begin errors++; $display("FAIL illegal_O k=%0d r=%0d: got %h want 00", ik[t], ir[t], o); end
         if (out_err !== 1'b1) begin errors++; $display("FAIL illegal_err k=%0d r=%0d: got %b want 1", ik[t], ir[t], out_err); end
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_sweep();
      logic [3:0] sk [256];
      logic [6:0] sr [256];
      bit seen [256];
      int n = 0;
      int lat;
      int w;
      int last_acc = 0;
      for (int k = 0; k <= 8; k++)
         for (int r = 0; r < pas[8][k]; r++) begin
            sk[n] = 4'(k);
            sr[n] = 7'(r);
            n++;
         end
      out_ready = 1'b1;
      in_count = sk[0];
      in_rank = sr[0];
      in_valid = 1'b1;
      for (int t = 0; t < 256; t++) begin
         w = 0;
         while (!in_ready && w < 30) begin tick(); w++; end
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready #%0d: got %b want 1", t, in_ready); end
         if (t > 0) begin
            checks++;
            if (cyc - last_acc != 10) begin errors++; $display("FAIL sweep_period #%0d: got %0d want 10", t, cyc - last_acc); end
         end
         last_acc = cyc;
         tick();
         if (t < 255) begin in_count = sk[t+1]; in_rank = sr[t+1]; end
         else in_valid = 1'b0;
         wait_valid(lat);
         checks += 5;
         if (lat != 8) begin errors++; $display("FAIL sweep_latency k=%0d r=%0d: got %0d want 8", sk[t], sr[t], lat); end
         if (out_err !== 1'b0) begin errors++; $display("FAIL sweep_err k=%0d r=%0d: got %b want 0", sk[t], sr[t], out_err); end
         if ($countones(o) != int'(sk[t])) begin errors++; $display("FAIL sweep_popcount k=%0d r=%0d: O=%h popcount %0d", sk[t], sr[t], o, $countones(o)); end
         if (colex_rank(o) != int'(sr[t])) begin errors++; $display("FAIL sweep_rank k=%0d r=%0d: O=%h rank %0d", sk[t], sr[t], o, colex_rank(o)); end
         if (seen[o]) begin errors++; $display("FAIL sweep_distinct k=%0d r=%0d: O=%h repeated", sk[t], sr[t], o); end
         seen[o] = 1'b1;
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit rose = 1'b0;
      out_ready = 1'b1;
      send(4'd3, 7'd10);
      tick();
      tick();
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
      for (int c = 0; c < 15; c++) begin
         if (out_valid) rose = 1'b1;
         tick();
      end
      checks++;
      if (rose) begin errors++; $display("FAIL rstmid_no_output: out_valid rose=1 want 0"); end
      out_ready = 1'b0;
      send(4'd1, 7'd7);
      wait_valid(lat);
      checks += 3;
      if (lat != 8) begin errors++; $display("FAIL rstmid_latency: got %0d want 8", lat); end
      if (o !== 8'h80) begin errors++; $display("FAIL rstmid_O: got %h want 80", o); end
      if (out_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b want 0", out_err); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lat = 0;
      out_ready = 1'b0;
      in_count = 4'd3;
      in_rank = 7'd55;
      in_valid = 1'b1;
      tick();
      while (!out_valid && lat < 40) begin
         in_count = 4'(lat);
         in_rank = 7'(lat * 9 + 1);
         tick();
         lat++;
      end
      checks += 2;
      if (lat != 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", lat); end
      if (o !== 8'hE0) begin errors++; $display("FAIL b2b_O: got %h want E0", o); end
      for (int c = 0; c < 2; c++) begin
         in_count = 4'(c + 5);
         in_rank = 7'(c);
         tick();
         checks++;
         if (o !== 8'hE0) begin errors++; $display("FAIL b2b_done_hold: cycle %0d got %h want E0", c, o); end
      end
      in_count = 4'd4;
      in_rank = 7'd69;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks += 2;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_hs_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after_hs_valid: got %b want 0", out_valid); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_next_accept: in_ready=%b want 0", in_ready); end
      wait_valid(lat);
      checks += 2;
      if (lat != 8) begin errors++; $display("FAIL b2b_second_latency: got %0d want 8", lat); end
      if (o !== 8'hF0) begin errors++; $display("FAIL b2b_second_O: got %h want F0", o); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      for (int n = 0; n <= 8; n++)
         for (int m = 0; m <= 8; m++)
            pas[n][m] = (m == 0) ? 1 : (n == 0) ? 0 : pas[n-1][m-1] + ((m <= n - 1) ? pas[n-1][m] : 0);
      test_reset();
      test_basic();
      test_corners();
      test_illegal();
      test_sweep();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
